avr_keys: RTL and testbench



---
 rtl/avr_keys_pkg.sv | 22 ++
 rtl/avr_key_channel.sv | 107 ++++++++++
 rtl/avr_keys.sv | 60 ++++++
 tb/tb_avr_keys.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/avr_keys_pkg.sv
// Shared types, widths and parameter legality check for the avr_keys front end.
package avr_keys_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } key_state_t;

    localparam int CNT_W = 4;
    localparam int RC_W  = 8;

    function automatic bit params_ok(input int tick_div, input int cnt_max,
                                     input int rep_delay, input int rep_rate);
        bit ok;
        ok = (tick_div >= 2) && (cnt_max >= 1) && (cnt_max <= 15) &&
             (rep_delay >= 0) && (rep_delay <= 255);
        if (rep_delay != 0)
            ok = ok && (rep_rate >= 1) && (rep_rate <= rep_delay);
        return ok;
    endfunction

endpackage

// File: rtl/avr_key_channel.sv
// One key: two-flop synchroniser, tick-paced debounce and auto-repeat pulse generation.
module avr_key_channel
    import avr_keys_pkg::*;
#(
    parameter int CNT_MAX    = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int REP_DELAY  = 250,
    parameter int REP_RATE   = 50
) (
    input  logic clock,
    input  logic locked,
    input  logic tick,
    input  logic key_in,
    output logic level,
    output logic pressed,
    output logic released,
    output logic rep_pulse
);

    localparam logic [CNT_W:0]   CNT_LIM    = (CNT_W+1)'(CNT_MAX);
    localparam logic [RC_W:0]    REP_LIM    = (RC_W+1)'(REP_DELAY);
    localparam logic [RC_W-1:0]  REP_RELOAD = RC_W'(REP_DELAY - REP_RATE);
    localparam logic             IDLE_PIN   = (ACTIVE_LOW != 0);

    logic             q1, q2, s;
    key_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic [RC_W-1:0]  rc, rc_next;
    logic [RC_W:0]    rc_inc;
    logic             flip, press_next, release_next, rep_next;

    // Flops reset to the idle pin level so the first sample after reset reads "not pressed".
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            q1 <= IDLE_PIN;
            q2 <= IDLE_PIN;
        end else begin
            q1 <= key_in;
            q2 <= q1;
        end
    end

    assign s       = (ACTIVE_LOW != 0) ? ~q2 : q2;
    assign level   = (state == DOWN);
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign rc_inc  = {1'b0, rc} + (RC_W+1)'(1);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rc_next      = rc;
        flip         = 1'b0;
        press_next   = 1'b0;
        release_next = 1'b0;
        rep_next     = 1'b0;
        if (tick) begin
            if (s != level) begin
                if (cnt_inc == CNT_LIM) begin
                    flip         = 1'b1;
                    state_next   = (state == UP) ? DOWN : UP;
                    cnt_next     = '0;
                    rc_next      = '0;
                    press_next   = (state == UP);
                    release_next = (state == DOWN);
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end else begin
                cnt_next = '0;
            end

            // Repeat counting continues through a release bounce; only an actual flip restarts it.
            if (!flip) begin
                if (state == UP) begin
                    rc_next = '0;
                end else if (REP_DELAY != 0) begin
                    if (rc_inc == REP_LIM) begin
                        rep_next = 1'b1;
                        rc_next  = REP_RELOAD;
                    end else begin
                        rc_next = rc_inc[RC_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            state     <= UP;
            cnt       <= '0;
            rc        <= '0;
            pressed   <= 1'b0;
            released  <= 1'b0;
            rep_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rc        <= rc_next;
            pressed   <= press_next;
            released  <= release_next;
            rep_pulse <= rep_next;
        end
    end

endmodule

// File: rtl/avr_keys.sv
// Eight-channel key front end for the AVR core port0: shared ms prescaler plus eight debounce channels.
// The auto-repeat output is named rep_pulse because "repeat" is a reserved word.
module avr_keys
    import avr_keys_pkg::*;
#(
    parameter int TICK_DIV   = 25000,
    parameter int CNT_MAX    = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int REP_DELAY  = 250,
    parameter int REP_RATE   = 50
) (
    input  logic       clock,
    input  logic       locked,
    input  logic [7:0] keys_in,
    output logic [7:0] port0,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic [7:0] rep_pulse,
    output logic       tick
);

    localparam int               PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;

    if (!params_ok(TICK_DIV, CNT_MAX, REP_DELAY, REP_RATE)) begin : g_bad_params
        $error("avr_keys: illegal parameter combination");
    end

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clock or negedge locked) begin
        if (!locked)
            pre <= '0;
        else if (tick)
            pre <= '0;
        else
            pre <= pre + PRE_W'(1);
    end

    for (genvar i = 0; i < 8; i++) begin : g_chan
        avr_key_channel #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .REP_DELAY  (REP_DELAY),
            .REP_RATE   (REP_RATE)
        ) u_chan (
            .clock     (clock),
            .locked    (locked),
            .tick      (tick),
            .key_in    (keys_in[i]),
            .level     (port0[i]),
            .pressed   (pressed[i]),
            .released  (released[i]),
            .rep_pulse (rep_pulse[i])
        );
    end

endmodule

// File: tb/tb_avr_keys.sv
// Self-checking bench for avr_keys: directed scenarios plus random key activity against a tick-history model.
module tb_avr_keys;

    localparam int TD = 4;
    localparam int CM = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic       clock = 1'b0;
    logic       locked;
    logic [7:0] keys_in;
    logic [7:0] port0, pressed, released, rep_pulse;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Model: synchroniser delay line, per-tick sample history, and ticks held since the press.
    logic [7:0] m_sync1, m_sync2, m_level, m_press, m_rel, m_rep;
    logic [7:0] hist [0:CM-1];
    int         held [0:7];
    int         m_cyc;
    logic       m_tick;

    avr_keys #(
        .TICK_DIV   (TD),
        .CNT_MAX    (CM),
        .ACTIVE_LOW (1),
        .REP_DELAY  (RD),
        .REP_RATE   (RR)
    ) dut (
        .clock     (clock),
        .locked    (locked),
        .keys_in   (keys_in),
        .port0     (port0),
        .pressed   (pressed),
        .released  (released),
        .rep_pulse (rep_pulse),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_sync1 = '0; m_sync2 = '0; m_level = '0;
        m_press = '0; m_rel = '0; m_rep = '0;
        m_cyc = 0; m_tick = 1'b0;
        for (int k = 0; k < CM; k++) hist[k] = '0;
        for (int i = 0; i < 8; i++) held[i] = 0;
    endtask

    // A level flips once the last CM tick samples all disagree with it.
    task automatic model_step();
        logic [7:0] s;
        bit all_diff;
        if (!locked) begin
            model_reset();
            return;
        end
        s = m_sync2;
        m_press = '0; m_rel = '0; m_rep = '0;
        if (m_cyc % TD == TD - 1) begin
            for (int k = CM - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < CM; k++)
                    if (hist[k][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        held[i] = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end else if (m_level[i]) begin
                    held[i]++;
                    if (RD != 0 && held[i] >= RD && (held[i] - RD) % RR == 0)
                        m_rep[i] = 1'b1;
                end
            end
        end
        m_cyc++;
        m_tick = (m_cyc % TD == TD - 1);
        m_sync2 = m_sync1;
        m_sync1 = ~keys_in;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_cycle();
        @(posedge clock);
        model_step();
        #1;
        check_output("port0", port0, m_level);
        check_output("pressed", pressed, m_press);
        check_output("released", released, m_rel);
        check_output("repeat", rep_pulse, m_rep);
        check_output("tick", {7'b0, tick}, {7'b0, m_tick});
    endtask

    // kind: 0 pressed, 1 released, 2 repeat. n = cycles waited, -1 on timeout.
    task automatic wait_event(input int kind, input logic [7:0] mask, input int bound,
                              input string tag, output int n);
        logic [7:0] sig;
        n = -1;
        for (int c = 1; c <= bound; c++) begin
            apply_cycle();
            sig = (kind == 0) ? pressed : (kind == 1) ? released : rep_pulse;
            if ((sig & mask) != 0) begin
                n = c;
                break;
            end
        end
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("[TB] FAIL %s_timeout observed none expected event within %0d cycles", tag, bound);
        end
    endtask

    initial begin
        int n;
        logic [7:0] seen;

        model_reset();
        locked  = 1'b0;
        keys_in = 8'h00;
        repeat (6) apply_cycle();

        $display("[TB] reset release with all keys held");
        locked = 1'b1;
        wait_event(0, 8'hFF, 40, "reset_press", n);
        check_output("reset_no_early_event", {7'b0, (n >= 10)}, 8'h01);
        check_output("reset_press_all", pressed, 8'hFF);
        keys_in = 8'hFF;
        wait_event(1, 8'hFF, 30, "reset_release", n);
        check_output("release_all", released, 8'hFF);
        repeat (8) apply_cycle();

        $display("[TB] clean press on key 0");
        keys_in = 8'hFE;
        wait_event(0, 8'h01, 30, "clean_press", n);
        check_output("press_latency_in_range", {7'b0, (n >= 11 && n <= 15)}, 8'h01);
        check_output("clean_pressed", pressed, 8'h01);
        check_output("clean_port0", port0, 8'h01);
        apply_cycle();
        check_output("clean_pulse_one_cycle", pressed, 8'h00);
        keys_in = 8'hFF;
        wait_event(1, 8'h01, 30, "clean_release", n);
        repeat (8) apply_cycle();

        $display("[TB] bounce on key 1");
        seen = '0;
        for (int t = 0; t < 20; t++) begin
            keys_in[1] = ~keys_in[1];
            for (int c = 0; c < TD; c++) begin
                apply_cycle();
                seen = seen | pressed | released | rep_pulse | port0;
            end
        end
        keys_in = 8'hFF;
        check_output("bounce_quiet", seen & 8'h02, 8'h00);
        repeat (8) apply_cycle();

        $display("[TB] auto-repeat on key 2");
        keys_in = 8'hFB;
        wait_event(0, 8'h04, 30, "rep_press", n);
        wait_event(2, 8'h04, 40, "rep_first", n);
        check_output("first_repeat_gap", 8'(n), 8'(RD * TD));
        wait_event(2, 8'h04, 20, "rep_second", n);
        check_output("second_repeat_gap", 8'(n), 8'(RR * TD));
        wait_event(2, 8'h04, 20, "rep_third", n);
        check_output("third_repeat_gap", 8'(n), 8'(RR * TD));
        keys_in = 8'hFF;
        wait_event(1, 8'h04, 30, "rep_release", n);
        seen = '0;
        for (int c = 0; c < 40; c++) begin
            apply_cycle();
            seen = seen | rep_pulse | released;
        end
        check_output("no_repeat_after_release", seen & 8'h04, 8'h00);

        $display("[TB] simultaneous press");
        keys_in = 8'h00;
        wait_event(0, 8'hFF, 30, "simul_press", n);
        check_output("simul_pressed", pressed, 8'hFF);
        check_output("simul_port0", port0, 8'hFF);

        $display("[TB] reset while holding key 3");
        keys_in = 8'hF7;
        wait_event(1, 8'hF7, 30, "others_release", n);
        check_output("others_released", released, 8'hF7);
        repeat (10) apply_cycle();
        locked = 1'b0;
        #1;
        check_output("async_reset_port0", port0, 8'h00);
        check_output("async_reset_released", released, 8'h00);
        repeat (3) apply_cycle();
        locked = 1'b1;
        wait_event(0, 8'h08, 30, "requalify", n);
        check_output("requalify_pressed", pressed, 8'h08);
        check_output("requalify_port0", port0, 8'h08);

        $display("[TB] random key activity");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0)
                keys_in = keys_in ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            apply_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
